// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Used by ram_1port_arbiter and ram_arb_rd_pipe.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } arb_state_t;

   // An owner that goes quiet releases the RAM after LOCK_TIMEOUT + 1 idle cycles.
   localparam logic [3:0] LOCK_TIMEOUT = 4'd15;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-return path: RD_LAT-deep {valid, id} shift register that tracks reads in flight,
// plus the rdata capture/hold mux feeding the shared read-data bus.
module ram_arb_rd_pipe
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_id,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata
);

   rd_tag_t           pipe [RD_LAT];
   rd_tag_t           ret;
   logic [DATA_W-1:0] rdata_hold;

   // NOTE: the tag pipeline is reset (unlike a data RAM) so no stale rvalid survives rst;
   // every register here uses <= so all stages shift on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
         rdata_hold <= '0;
      end else begin
         pipe[0] <= '{valid: issue_valid, id: issue_id};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
         if (ret.valid) rdata_hold <= ram_rd_data;
      end
   end

   assign ret     = pipe[RD_LAT-1];
   assign rvalid0 = ret.valid & ~ret.id;
   assign rvalid1 = ret.valid &  ret.id;
   assign rdata   = ret.valid ? ram_rd_data : rdata_hold;

endmodule

// File: rtl/ram_1port_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port RAM between two requesters.
// Optional grant/conflict statistics are built when RAM_ARB_STATS_EN is defined.
module ram_1port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              ram_wr_en,
   output logic              ram_rd_en,
`ifdef RAM_ARB_STATS_EN
   input  logic              stats_clr,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1,
   output logic [15:0]       conflict_cnt,
`endif
   input  logic [DATA_W-1:0] ram_rd_data
);

   arb_state_t        state;
   logic              rr_ptr;
   logic [3:0]        idle_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;
   logic              gnt_any;
   logic              sel_we;
   logic              sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // NOTE: both grants get a default before the case so no path leaves them unassigned (no latch).
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (state)
         IDLE: begin
            if (req0 && req1) begin
               gnt0 = ~rr_ptr;
               gnt1 =  rr_ptr;
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
         end
         OWN0:    gnt0 = req0;
         OWN1:    gnt1 = req1;
         default: ;
      endcase
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign gnt_any   = gnt0 | gnt1;
   assign sel_we    = gnt1 ? we1    : we0;
   assign sel_lock  = gnt1 ? lock1  : lock0;
   assign sel_addr  = gnt1 ? addr1  : addr0;
   assign sel_wdata = gnt1 ? wdata1 : wdata0;

   assign ram_wr_en   = gnt_any &  sel_we;
   assign ram_rd_en   = gnt_any & ~sel_we;
   assign ram_addr    = gnt_any ? sel_addr  : addr_hold;
   assign ram_wr_data = gnt_any ? sel_wdata : wdata_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         idle_cnt   <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         if (gnt_any) begin
            addr_hold  <= sel_addr;
            wdata_hold <= sel_wdata;
         end
         unique case (state)
            IDLE: begin
               // The tie winner was rr_ptr, so the loser gets priority next time.
               if (req0 && req1) rr_ptr <= ~rr_ptr;
               idle_cnt <= '0;
               if (gnt_any && sel_lock) state <= gnt1 ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
               if (gnt_any) begin
                  idle_cnt <= '0;
                  if (!sel_lock) begin
                     state  <= IDLE;
                     rr_ptr <= ~gnt1;
                  end
               end else if (idle_cnt == LOCK_TIMEOUT) begin
                  state    <= IDLE;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ram_arb_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (ram_rd_en),
      .issue_id    (gnt1),
      .ram_rd_data (ram_rd_data),
      .rvalid0     (rvalid0),
      .rvalid1     (rvalid1),
      .rdata       (rdata)
   );

`ifdef RAM_ARB_STATS_EN
   logic conflict;

   // A conflict is any cycle where a requester wants the RAM but must wait for the other.
   assign conflict = (req0 & req1) | ((state == OWN0) & req1) | ((state == OWN1) & req0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_cnt0     <= '0;
         gnt_cnt1     <= '0;
         conflict_cnt <= '0;
      end else if (stats_clr) begin
         gnt_cnt0     <= '0;
         gnt_cnt1     <= '0;
         conflict_cnt <= '0;
      end else begin
         if (gnt0)     gnt_cnt0     <= sat_inc(gnt_cnt0);
         if (gnt1)     gnt_cnt1     <= sat_inc(gnt_cnt1);
         if (conflict) conflict_cnt <= sat_inc(conflict_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Self-checking bench for ram_1port_arbiter: directed scenarios plus random traffic
// compared against a behavioural ownership/priority model and a reference memory.
`timescale 1ns/1ps
module tb_ram_1port_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 1;
   localparam int BUS_W  = 4 + ADDR_W + DATA_W + 2 + DATA_W;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] req, we, lock;
   logic [ADDR_W-1:0] addr [2];
   logic [DATA_W-1:0] wdata [2];
   logic gnt0, gnt1, rvalid0, rvalid1, ram_wr_en, ram_rd_en;
   logic [DATA_W-1:0] rdata, ram_wr_data;
   logic [DATA_W-1:0] ram_rd_data = '0;
   logic [ADDR_W-1:0] ram_addr;
`ifdef RAM_ARB_STATS_EN
   logic stats_clr;
   logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int contract_viol = 0;

   always #5 clk = ~clk;

   ram_1port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .lock0(lock[0]), .lock1(lock[1]), .addr0(addr[0]), .addr1(addr[1]),
      .wdata0(wdata[0]), .wdata1(wdata[1]),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
`ifdef RAM_ARB_STATS_EN
      .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt),
`endif
      .ram_rd_data(ram_rd_data)
   );

   // Single-port RAM with one-cycle registered read.
   logic [DATA_W-1:0] ram_mem [32] = '{default: '0};
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= ram_mem[ram_addr];
   end

   // Requester contract: fields stay stable while a request waits for its grant.
   logic [1:0] hold_v = '0;
   logic [1+1+ADDR_W+DATA_W-1:0] hold_f [2];
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (hold_v[i] && req[i] && !rst)
            assert ({we[i], lock[i], addr[i], wdata[i]} == hold_f[i])
            else begin
               $display("FAIL contract req%0d fields changed while waiting", i);
               contract_viol++;
            end
         hold_v[i] <= req[i] && !((i == 0) ? gnt0 : gnt1) && !rst;
         hold_f[i] <= {we[i], lock[i], addr[i], wdata[i]};
      end
   end

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int                due;
      int                id;
      logic [DATA_W-1:0] data;
   } rd_ret_t;

   int      m_owner;     // -1: nobody owns the RAM
   int      m_idle;      // owner's consecutive ungranted cycles
   bit      m_prio;      // requester that wins the next tie
   int      cyc = 0;
   int      exp_g;
   rd_ret_t rd_q [$];
   logic [ADDR_W-1:0] m_last_addr;
   logic [DATA_W-1:0] m_last_wdata, m_last_rdata;
   logic [DATA_W-1:0] ref_mem [32] = '{default: '0};
   logic [BUS_W-1:0]  exp_bus;

   function automatic void model_reset();
      m_owner = -1;
      m_idle = 0;
      m_prio = 1'b0;
      m_last_addr = '0;
      m_last_wdata = '0;
      m_last_rdata = '0;
      rd_q.delete();
   endfunction

   function automatic int pick_grant();
      if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
      if (req == 2'b11) return int'(m_prio);
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
   endfunction

   function automatic void model_eval();
      logic [1:0] g_v, rv;
      logic wr, rd;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, rdv;
      exp_g = pick_grant();
      g_v = '0; wr = 1'b0; rd = 1'b0; a = m_last_addr; d = m_last_wdata;
      if (exp_g >= 0) begin
         g_v[exp_g] = 1'b1;
         wr = we[exp_g];
         rd = !we[exp_g];
         a = addr[exp_g];
         d = wdata[exp_g];
      end
      rv = '0; rdv = m_last_rdata;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
         rv[rd_q[0].id] = 1'b1;
         rdv = rd_q[0].data;
      end
      exp_bus = {g_v[1], g_v[0], wr, rd, a, d, rv[1], rv[0], rdv};
   endfunction

   function automatic void model_commit();
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
         m_last_rdata = rd_q[0].data;
         void'(rd_q.pop_front());
      end
      if (exp_g >= 0) begin
         m_last_addr = addr[exp_g];
         m_last_wdata = wdata[exp_g];
         if (we[exp_g]) ref_mem[addr[exp_g]] = wdata[exp_g];
         else rd_q.push_back('{due: cyc + RD_LAT, id: exp_g, data: ref_mem[addr[exp_g]]});
      end
      if (m_owner < 0) begin
         if (req == 2'b11) m_prio = (exp_g == 0);
         if (exp_g >= 0 && lock[exp_g]) begin
            m_owner = exp_g;
            m_idle = 0;
         end
      end else if (exp_g >= 0) begin
         m_idle = 0;
         if (!lock[exp_g]) begin
            m_owner = -1;
            m_prio = (exp_g == 0);
         end
      end else begin
         m_idle++;
         if (m_idle == 16) m_owner = -1;
      end
      cyc++;
   endfunction

   function automatic logic [BUS_W-1:0] obs_bus();
      return {gnt1, gnt0, ram_wr_en, ram_rd_en, ram_addr, ram_wr_data, rvalid1, rvalid0, rdata};
   endfunction

   // Inputs are driven at posedge+1; outputs are sampled at posedge+4.
   task automatic settle();
      model_eval();
      #3;
   endtask

   task automatic advance();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      req = '0; we = '0; lock = '0;
      model_reset();
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      req = 2'b11; we = '0; lock = '0;
      addr[0] = 5'd9; addr[1] = 5'd10; wdata[0] = 8'h11; wdata[1] = 8'h22;
      model_reset();
      #2;
      n_checks++;
      if (obs_bus() !== '0) begin
         $display("FAIL reset_outputs got=%h exp=0", obs_bus());
         n_fail++;
      end
      req = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      settle();
      n_checks++;
      if (obs_bus() !== exp_bus) begin
         $display("FAIL reset_idle got=%h exp=%h", obs_bus(), exp_bus);
         n_fail++;
      end
      advance();
   endtask

   task automatic test_single();
      req = 2'b01; we[0] = 1'b1; lock = '0; addr[0] = 5'd5; wdata[0] = 8'hA5;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL single_bus k=%0d got=%h exp=%h", k, obs_bus(), exp_bus);
            n_fail++;
         end
         n_checks++;
         if (k == 0 && !(gnt0 === 1'b1 && ram_wr_en === 1'b1 && gnt1 === 1'b0)) begin
            $display("FAIL single_write gnt0=%b wr_en=%b gnt1=%b exp 1 1 0", gnt0, ram_wr_en, gnt1);
            n_fail++;
         end else if (k == 1 && !(gnt0 === 1'b1 && ram_rd_en === 1'b1 && gnt1 === 1'b0)) begin
            $display("FAIL single_read gnt0=%b rd_en=%b gnt1=%b exp 1 1 0", gnt0, ram_rd_en, gnt1);
            n_fail++;
         end else if (k == 2 && !(rvalid0 === 1'b1 && rdata === 8'hA5 && gnt1 === 1'b0)) begin
            $display("FAIL single_return rvalid0=%b rdata=%h gnt1=%b exp 1 a5 0", rvalid0, rdata, gnt1);
            n_fail++;
         end
         advance();
         if (k == 0) we[0] = 1'b0;
         if (k == 1) req = '0;
      end
   endtask

   task automatic test_contention();
      logic [DATA_W-1:0] exp_data [6];
      lock = '0;
      for (int k = 0; k < 6; k++) begin
         req = (k % 2 == 0) ? 2'b01 : 2'b10;
         we[k % 2] = 1'b1;
         addr[k % 2] = ADDR_W'(10 + k);
         exp_data[k] = DATA_W'($urandom);
         wdata[k % 2] = exp_data[k];
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL contention_prewrite k=%0d got=%h exp=%h", k, obs_bus(), exp_bus);
            n_fail++;
         end
         advance();
      end
      req = '0;
`ifdef RAM_ARB_STATS_EN
      stats_clr = 1'b1;
`endif
      settle();
      advance();
`ifdef RAM_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      req = 2'b11; we = '0; addr[0] = 5'd10; addr[1] = 5'd11;
      for (int k = 0; k < 7; k++) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL contention_bus k=%0d got=%h exp=%h", k, obs_bus(), exp_bus);
            n_fail++;
         end
         if (k < 6) begin
            n_checks++;
            if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
               $display("FAIL contention_order k=%0d gnt=%b%b", k, gnt1, gnt0);
               n_fail++;
            end
         end
         if (k > 0) begin
            n_checks++;
            if ({rvalid1, rvalid0} !== (((k - 1) % 2 == 0) ? 2'b01 : 2'b10) || rdata !== exp_data[k-1]) begin
               $display("FAIL contention_return k=%0d rvalid=%b%b rdata=%h exp_data=%h",
                        k, rvalid1, rvalid0, rdata, exp_data[k-1]);
               n_fail++;
            end
         end
         advance();
         if (k < 6) begin
            addr[k % 2] = addr[k % 2] + ADDR_W'(2);
            if (k >= 4) req[k % 2] = 1'b0;
         end
      end
`ifdef RAM_ARB_STATS_EN
      n_checks++;
      if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd3 || conflict_cnt !== 16'd5) begin
         $display("FAIL stats_counts got %0d %0d %0d exp 3 3 5", gnt_cnt0, gnt_cnt1, conflict_cnt);
         n_fail++;
      end
      req = 2'b01; we[0] = 1'b1; addr[0] = 5'd30; wdata[0] = 8'h3C; stats_clr = 1'b1;
      settle();
      advance();
      stats_clr = 1'b0; req = '0;
      n_checks++;
      if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0 || conflict_cnt !== 16'd0) begin
         $display("FAIL stats_clear got %0d %0d %0d exp 0 0 0", gnt_cnt0, gnt_cnt1, conflict_cnt);
         n_fail++;
      end
`endif
   endtask

   task automatic test_lock();
      apply_reset(2);
      req = 2'b11; we[0] = 1'b1; we[1] = 1'b0; addr[1] = 5'd3; lock[1] = 1'b0;
      for (int b = 0; b < 6; b++) begin
         if (b < 4) begin
            addr[0] = ADDR_W'(20 + b);
            wdata[0] = DATA_W'($urandom);
            lock[0] = (b < 3);
         end
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL lock_bus b=%0d got=%h exp=%h", b, obs_bus(), exp_bus);
            n_fail++;
         end
         if (b < 5) begin
            n_checks++;
            if ({gnt1, gnt0} !== ((b < 4) ? 2'b01 : 2'b10)) begin
               $display("FAIL lock_hold b=%0d gnt=%b%b", b, gnt1, gnt0);
               n_fail++;
            end
         end
         advance();
         if (b == 3) begin
            req[0] = 1'b0;
            lock[0] = 1'b0;
         end
         if (b == 4) req = '0;
      end
   endtask

   task automatic test_timeout();
      int waited;
      bit got;
      req = 2'b01; we[0] = 1'b1; lock[0] = 1'b1; addr[0] = 5'd7; wdata[0] = 8'h77;
      settle();
      n_checks++;
      if (obs_bus() !== exp_bus || gnt0 !== 1'b1) begin
         $display("FAIL timeout_lockgrant got=%h exp=%h", obs_bus(), exp_bus);
         n_fail++;
      end
      advance();
      req = 2'b10; lock = '0; we[1] = 1'b0; addr[1] = 5'd8;
      waited = 0;
      got = 1'b0;
      while (!got && waited < 40) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL timeout_bus w=%0d got=%h exp=%h", waited, obs_bus(), exp_bus);
            n_fail++;
         end
         if (gnt1 === 1'b1) got = 1'b1;
         else waited++;
         advance();
      end
      n_checks++;
      if (!got || waited != 16) begin
         $display("FAIL timeout_len got_gnt=%0b idle_cycles=%0d exp 16", got, waited);
         n_fail++;
      end
      req = '0;
      settle();
      advance();
   endtask

   task automatic test_reset_mid_read();
      bit won0;
      req = 2'b11; we = '0; lock = '0; addr[0] = 5'd1; addr[1] = 5'd2;
      for (int t = 0; t < 2; t++) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL midrd_tie t=%0d got=%h exp=%h", t, obs_bus(), exp_bus);
            n_fail++;
         end
         won0 = (exp_g == 0);
         advance();
         if (won0) break;
         addr[1] = 5'd3;
      end
      rst = 1'b1;
      req = '0;
      model_reset();
      for (int r = 0; r < 3; r++) begin
         #2;
         n_checks++;
         if (obs_bus() !== '0) begin
            $display("FAIL midrd_reset r=%0d got=%h exp=0", r, obs_bus());
            n_fail++;
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      req = 2'b11; addr[0] = 5'd4; addr[1] = 5'd6;
      for (int k = 0; k < 3; k++) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL midrd_after k=%0d got=%h exp=%h", k, obs_bus(), exp_bus);
            n_fail++;
         end
         if (k == 0) begin
            n_checks++;
            if ({gnt1, gnt0} !== 2'b01) begin
               $display("FAIL midrd_prio gnt=%b%b exp 01", gnt1, gnt0);
               n_fail++;
            end
         end
         advance();
         if (k == 0) req[0] = 1'b0;
         if (k == 1) req = '0;
      end
   endtask

   task automatic test_random();
      logic [1:0] g;
      for (int c = 0; c < 600; c++) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL random_bus c=%0d got=%h exp=%h", c, obs_bus(), exp_bus);
            n_fail++;
         end
         g = {gnt1, gnt0};
         advance();
         for (int i = 0; i < 2; i++) begin
            if (!req[i] || g[i]) begin
               if ($urandom_range(0, 3) != 0) begin
                  req[i]   = 1'b1;
                  we[i]    = 1'($urandom_range(0, 1));
                  lock[i]  = ($urandom_range(0, 3) == 0);
                  addr[i]  = ADDR_W'($urandom_range(0, 7));
                  wdata[i] = DATA_W'($urandom);
               end else begin
                  req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
      req = '0;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_checks++;
         if (obs_bus() !== exp_bus) begin
            $display("FAIL random_drain c=%0d got=%h exp=%h", c, obs_bus(), exp_bus);
            n_fail++;
         end
         advance();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req = '0; we = '0; lock = '0;
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
`ifdef RAM_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      test_reset();
      test_single();
      test_contention();
      test_lock();
      test_timeout();
      test_reset_mid_read();
      test_random();
      n_fail += contract_viol;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
